// File: rtl/tff_ctrl_pkg.sv
// Shared types and the round-robin pick helper for the TFF toggle arbiter.
package tff_ctrl_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        HOLDOFF = 1'b1
    } state_t;

    // First set bit of elig searching upward from last+1 with wrap over n requesters.
    function automatic int rr_pick(input logic [7:0] elig, input int last, input int n);
        int pick;
        int c;
        pick = 0;
        for (int k = 8; k >= 1; k--) begin
            if (k <= n) begin
                c = last + k;
                if (c >= n) c = c - n;
                if (elig[c[2:0]]) pick = c;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tff_toggle_arbiter_if.sv
// Request/grant handshake bundle between requesters and the TFF toggle arbiter.
interface tff_toggle_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDXW = 3
);
    localparam int GIDW = $clog2(NREQ);

    logic [NREQ-1:0]      req;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ-1:0]      ack;
    logic [GIDW-1:0]      grant_id;

    modport master (output req, output req_idx, input ack, input grant_id);
    modport slave  (input req, input req_idx, output ack, output grant_id);
endinterface

// File: rtl/tff_cell.sv
// Single T flip-flop; clear wins over toggle.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic i_t,
    input  logic i_clr,
    output logic o_q
);
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_q <= 1'b0;
        else if (i_clr) r_q <= 1'b0;
        else if (i_t)   r_q <= ~r_q;
    end

    assign o_q = r_q;
endmodule

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter applying one toggle per grant to a bank of T flip-flops.
// Optional macro TFF_TOGGLE_CNT_EN adds the o_toggle_cnt applied-toggle counter.
module tff_toggle_arbiter
    import tff_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 3,
    parameter int HOLDW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    tff_toggle_arbiter_if.slave  bus,
    input  logic                 i_clr,
    input  logic [HOLDW-1:0]     i_holdoff_cfg,
    output logic [WIDTH-1:0]     o_q,
    output logic                 o_busy,
    output logic                 o_err
`ifdef TFF_TOGGLE_CNT_EN
    ,
    output logic [15:0]          o_toggle_cnt
`endif
);
    localparam int GIDW = $clog2(NREQ);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [HOLDW-1:0] r_hold;
    logic [HOLDW-1:0] w_hold_nxt;
    logic [GIDW-1:0]  r_last;
    logic [GIDW-1:0]  r_grant_id;
    logic [GIDW-1:0]  w_g;
    logic [NREQ-1:0]  r_ack;
    logic [NREQ-1:0]  w_elig;
    logic [7:0]       w_elig8;
    logic [IDXW-1:0]  w_idx;
    logic             w_grant;
    logic             w_in_range;
    logic             r_err;
    logic [WIDTH-1:0] w_t;

    // The requester acked this cycle is masked so a lingering req is not re-granted.
    assign w_elig = bus.req & ~r_ack;

    always_comb begin
        w_elig8             = '0;
        w_elig8[NREQ-1:0]   = w_elig;
    end

    assign w_g        = GIDW'(rr_pick(w_elig8, int'(r_last), NREQ));
    assign w_grant    = (r_state == IDLE) && (|w_elig) && !i_clr;
    assign w_idx      = bus.req_idx[int'(w_g)*IDXW +: IDXW];
    assign w_in_range = (32'(w_idx) < 32'(WIDTH));

    always_comb begin
        w_t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_t[i] = w_grant && w_in_range && (32'(w_idx) == 32'(i));
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
        tff_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .i_t   (w_t[gi]),
            .i_clr (i_clr),
            .o_q   (o_q[gi])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // The grant cycle itself counts as the first of the H hold-off cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        case (r_state)
            IDLE: begin
                if (w_grant && (i_holdoff_cfg != '0)) begin
                    w_state_nxt = HOLDOFF;
                    w_hold_nxt  = i_holdoff_cfg;
                end
            end
            HOLDOFF: begin
                w_hold_nxt = r_hold - HOLDW'(1);
                if (r_hold == HOLDW'(1)) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack      <= '0;
            r_last     <= GIDW'(NREQ - 1);
            r_grant_id <= '0;
            r_err      <= 1'b0;
        end else begin
            r_ack <= '0;
            if (w_grant) begin
                r_ack[w_g] <= 1'b1;
                r_last     <= w_g;
                r_grant_id <= w_g;
                if (!w_in_range) r_err <= 1'b1;
            end
        end
    end

`ifdef TFF_TOGGLE_CNT_EN
    logic [15:0] r_toggle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       r_toggle_cnt <= '0;
        else if (w_grant && w_in_range) r_toggle_cnt <= r_toggle_cnt + 16'd1;
    end

    assign o_toggle_cnt = r_toggle_cnt;
`endif

    assign bus.ack      = r_ack;
    assign bus.grant_id = r_grant_id;
    assign o_busy       = (r_state == HOLDOFF);
    assign o_err        = r_err;
endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Scoreboard bench for tff_toggle_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_tff_toggle_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 6;
    localparam int IDXW  = 3;
    localparam int HOLDW = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_clr = 1'b0;
    logic [HOLDW-1:0] hcfg = '0;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             err;
`ifdef TFF_TOGGLE_CNT_EN
    logic [15:0]      tcnt;
`endif

    tff_toggle_arbiter_if #(.NREQ(NREQ), .IDXW(IDXW)) bus ();

    tff_toggle_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW), .HOLDW(HOLDW)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .i_clr         (i_clr),
        .i_holdoff_cfg (hcfg),
        .o_q           (q),
        .o_busy        (busy),
        .o_err         (err)
`ifdef TFF_TOGGLE_CNT_EN
        ,
        .o_toggle_cnt  (tcnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int stamp;
        int g;
    } exp_t;

    exp_t             sb[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    int               cyc = 0;
    logic             run = 1'b0;
    logic             auto_drop = 1'b0;
    logic [IDXW-1:0]  idx [NREQ];

    // Reference state: bank contents, visible ack, rotation point, end of busy window.
    logic [WIDTH-1:0] m_q;
    logic [NREQ-1:0]  m_ack;
    logic             m_err;
    int               m_last;
    int               m_cnt;
    int               m_busy_end;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q        = '0;
        m_ack      = '0;
        m_err      = 1'b0;
        m_last     = NREQ - 1;
        m_cnt      = 0;
        m_busy_end = 0;
        sb.delete();
    endtask

    // Predict the effect of the coming edge, then advance one clock and commit.
    task automatic step();
        int               g;
        int               c;
        logic [WIDTH-1:0] nq;
        logic             nerr;
        int               ncnt;
        logic [NREQ-1:0]  nack;
        int               nbusy_end;
        exp_t             e;
        if (auto_drop) bus.req = bus.req & ~m_ack;
        for (int k = 0; k < NREQ; k++) bus.req_idx[k*IDXW +: IDXW] = idx[k];
        nq        = m_q;
        nerr      = m_err;
        ncnt      = m_cnt;
        nack      = '0;
        nbusy_end = m_busy_end;
        g         = -1;
        if (cyc >= m_busy_end && !i_clr) begin
            for (int k = 1; k <= NREQ && g < 0; k++) begin
                c = (m_last + k) % NREQ;
                if (bus.req[c] && !m_ack[c]) g = c;
            end
        end
        if (i_clr) nq = '0;
        if (g >= 0) begin
            nack[g] = 1'b1;
            if (int'(idx[g]) < WIDTH) begin
                nq[idx[g]] = ~nq[idx[g]];
                ncnt       = (ncnt + 1) % 65536;
            end else begin
                nerr = 1'b1;
            end
            nbusy_end = cyc + 1 + int'(hcfg);
            e.stamp   = cyc + 1;
            e.g       = g;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        m_q        = nq;
        m_err      = nerr;
        m_cnt      = ncnt;
        m_ack      = nack;
        m_busy_end = nbusy_end;
        if (g >= 0) m_last = g;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_grant_id", 32'(bus.grant_id), 0);
`ifdef TFF_TOGGLE_CNT_EN
        chk("rst_toggle_cnt", 32'(tcnt), 0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: per-cycle state checks, and scoreboard pops whenever an ack appears.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (run && !rst) begin
                chk("q", 32'(q), 32'(m_q));
                chk("busy", 32'(busy), 32'(cyc < m_busy_end));
                chk("err", 32'(err), 32'(m_err));
`ifdef TFF_TOGGLE_CNT_EN
                chk("toggle_cnt", 32'(tcnt), 32'(m_cnt));
`endif
                if (bus.ack != '0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ack", 32'(bus.ack), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("ack", 32'(bus.ack), 32'(1) << e.g);
                        chk("ack_cycle", 32'(cyc), 32'(e.stamp));
                        chk("grant_id", 32'(bus.grant_id), 32'(e.g));
                    end
                end else if (sb.size() > 0 && sb[0].stamp <= cyc) begin
                    e = sb.pop_front();
                    chk("missing_ack", 32'(bus.ack), 32'(1) << e.g);
                end
            end
        end
    end

    initial begin
        bus.req     = '0;
        bus.req_idx = '0;
        for (int k = 0; k < NREQ; k++) idx[k] = '0;
        model_reset();
        #2;
        @(posedge clk);
        #1;
        do_reset();
        run = 1'b1;

        // Single request, then withdrawn.
        idx[0]  = 3'd3;
        bus.req = 4'b0001;
        step();
        chk("t1_ack", 32'(bus.ack), 32'h1);
        chk("t1_q", 32'(q), 32'h08);
        chk("t1_grant_id", 32'(bus.grant_id), 0);
        bus.req = '0;
        step();
        step();
        chk("t1_no_ack", 32'(bus.ack), 0);

        // All requesting, rotation.
        do_reset();
        for (int k = 0; k < NREQ; k++) idx[k] = IDXW'(k);
        bus.req = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            step();
            chk("t2_rotate_ack", 32'(bus.ack), 32'(1) << i);
        end
        chk("t2_q", 32'(q), 32'h0F);
        step();
        chk("t2_wrap_ack", 32'(bus.ack), 32'h1);
        chk("t2_wrap_q", 32'(q), 32'h0E);

        // Hold-off of 3 between two grants.
        do_reset();
        bus.req   = '0;
        auto_drop = 1'b1;
        hcfg      = 4'd3;
        idx[0]    = 3'd1;
        idx[1]    = 3'd2;
        bus.req   = 4'b0011;
        step();
        chk("t3_first_ack", 32'(bus.ack), 32'h1);
        chk("t3_first_busy", 32'(busy), 1);
        for (int j = 1; j <= 3; j++) begin
            step();
            chk("t3_gap_ack", 32'(bus.ack), 0);
            chk("t3_gap_busy", 32'(busy), 32'(j < 3));
        end
        step();
        chk("t3_second_ack", 32'(bus.ack), 32'h2);

        // Two requesters on the same bit.
        do_reset();
        hcfg    = '0;
        idx[0]  = 3'd5;
        idx[2]  = 3'd5;
        bus.req = 4'b0101;
        step();
        step();
        chk("t4_second_ack", 32'(bus.ack), 32'h4);
        step();
        chk("t4_q", 32'(q), 0);
`ifdef TFF_TOGGLE_CNT_EN
        chk("t4_toggle_cnt", 32'(tcnt), 2);
`endif

        // Out-of-range index.
        do_reset();
        idx[0]  = 3'd7;
        bus.req = 4'b0001;
        step();
        chk("t5_ack", 32'(bus.ack), 32'h1);
        chk("t5_q", 32'(q), 0);
        chk("t5_err", 32'(err), 1);
        idx[1]  = 3'd2;
        bus.req = 4'b0010;
        step();
        step();
        chk("t5_err_sticky", 32'(err), 1);
        chk("t5_q_after", 32'(q), 32'h04);
`ifdef TFF_TOGGLE_CNT_EN
        chk("t5_toggle_cnt", 32'(tcnt), 1);
`endif

        // Clear while a request is pending, then reset in hold-off.
        do_reset();
        idx[0]  = 3'd1;
        bus.req = 4'b0001;
        step();
        idx[2]  = 3'd4;
        bus.req = 4'b0100;
        i_clr   = 1'b1;
        step();
        chk("t6_clr_ack", 32'(bus.ack), 0);
        chk("t6_clr_q", 32'(q), 0);
        i_clr = 1'b0;
        step();
        chk("t6_after_clr_ack", 32'(bus.ack), 32'h4);
        chk("t6_after_clr_q", 32'(q), 32'h10);
        hcfg    = 4'd5;
        idx[1]  = 3'd0;
        bus.req = 4'b0010;
        step();
        step();
        chk("t6_holdoff_busy", 32'(busy), 1);
        bus.req = 4'b1010;
        do_reset();
        hcfg = '0;
        step();
        chk("t6_post_rst_ack", 32'(bus.ack), 32'h2);

        // Randomized traffic.
        do_reset();
        bus.req = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!bus.req[k]) begin
                    if ($urandom_range(2) == 0) begin
                        idx[k]     = IDXW'($urandom_range(7));
                        bus.req[k] = 1'b1;
                    end
                end else if ($urandom_range(40) == 0) begin
                    bus.req[k] = 1'b0;
                end
            end
            i_clr = ($urandom_range(15) == 0);
            hcfg  = ($urandom_range(3) == 0) ? HOLDW'($urandom_range(4)) : '0;
            if ($urandom_range(300) == 0) do_reset();
            step();
        end

        bus.req = '0;
        i_clr   = 1'b0;
        hcfg    = '0;
        for (int n = 0; n < 10; n++) step();
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
